// File: rtl/mac_operand_sequencer_pkg.sv
// Shared types and constants for the MAC operand sequencer and its operand buffer.
package mac_operand_sequencer_pkg;

    localparam int unsigned ACC_W_DEFAULT = 32;
    localparam int unsigned OP_W          = 8;

    localparam logic WR_SEL_A = 1'b0;
    localparam logic WR_SEL_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mac_operand_sequencer_buffer.sv
// Two DEPTH x 8 operand arrays with one selectable write port and a common-address async read.
module mac_operand_buffer
    import mac_operand_sequencer_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_addr,
    input  logic [OP_W-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [OP_W-1:0] rd_a,
    output logic [OP_W-1:0] rd_b
);

    logic [OP_W-1:0] mem_a [DEPTH];
    logic [OP_W-1:0] mem_b [DEPTH];

    // Contents are intentionally not reset so loaded vectors survive a sequencer reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (wr_sel)
                WR_SEL_A: mem_a[wr_addr] <= wr_data;
                WR_SEL_B: mem_b[wr_addr] <= wr_data;
                default:  ;
            endcase
        end
    end

    assign rd_a = mem_a[rd_addr];
    assign rd_b = mem_b[rd_addr];

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds operand pairs to the 8x8->32 MAC (cleared first), then captures the accumulator as the dot product.
module mac_operand_sequencer
    import mac_operand_sequencer_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned ACC_W = ACC_W_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [AW-1:0]    wr_addr,
    input  logic [OP_W-1:0]  wr_data,
    input  logic [AW:0]      len,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    output logic [OP_W-1:0]  op_a,
    output logic [OP_W-1:0]  op_b,
    output logic             mac_en,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] mac_acc
);

    state_t            state, state_next;
    logic [AW-1:0]     idx, idx_next;
    logic [AW:0]       len_eff, len_eff_next;
    logic              wr_ok;
    logic [OP_W-1:0]   rd_a, rd_b;

    logic              busy_n, done_n, mac_en_n, mac_clr_n, rv_n;
    logic [OP_W-1:0]   op_a_n, op_b_n;
    logic [ACC_W-1:0]  result_n;

    assign wr_ok = wr_en && ((state == ST_IDLE) || (state == ST_DONE));

    // Read address is the next index so the operand register holds A[idx]/B[idx] during each RUN cycle.
    mac_operand_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_next),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    // Next-state, index and length latch.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        len_eff_next = len_eff;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_eff_next = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
                        state_next   = ST_CLEAR;
                    end else begin
                        state_next   = ST_DONE;
                    end
                end
            end
            ST_CLEAR: begin
                idx_next   = '0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                idx_next = idx + AW'(1);
                if ({1'b0, idx} == len_eff - (AW+1)'(1)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output values for the upcoming cycle, decoded from the state being entered.
    always_comb begin
        busy_n    = 1'b0;
        done_n    = 1'b0;
        mac_en_n  = 1'b0;
        mac_clr_n = 1'b0;
        op_a_n    = '0;
        op_b_n    = '0;
        result_n  = result;
        rv_n      = result_valid;
        case (state_next)
            ST_CLEAR: begin
                busy_n    = 1'b1;
                mac_clr_n = 1'b1;
                rv_n      = 1'b0;
            end
            ST_RUN: begin
                busy_n   = 1'b1;
                mac_en_n = 1'b1;
                op_a_n   = rd_a;
                op_b_n   = rd_b;
            end
            ST_DRAIN: busy_n = 1'b1;
            ST_DONE: begin
                done_n = 1'b1;
                rv_n   = 1'b1;
            end
            default: ;
        endcase
        if (state == ST_DRAIN) begin
            result_n = mac_acc;
        end else if ((state == ST_IDLE) && start && (len == '0)) begin
            result_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            len_eff      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mac_en       <= 1'b0;
            mac_clr      <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            len_eff      <= len_eff_next;
            busy         <= busy_n;
            done         <= done_n;
            mac_en       <= mac_en_n;
            mac_clr      <= mac_clr_n;
            op_a         <= op_a_n;
            op_b         <= op_b_n;
            result       <= result_n;
            result_valid <= rv_n;
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomised self-checking bench: a timeline-level model of the sequencer plus a falling-edge MAC model.
module tb_mac_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [4:0]  len = '0;
    logic        start = 1'b0;
    logic        busy, done, result_valid, mac_en, mac_clr;
    logic [31:0] result;
    logic [7:0]  op_a, op_b;
    logic [31:0] mac_acc = '0;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Model state describing the cycle currently in progress.
    int  a_m [16];
    int  b_m [16];
    bit  model_live = 0;
    bit  active = 0;
    int  k = 0;
    int  L = 0;
    int  exp_dot = 0;
    bit  rv_e = 0;
    int  res_e = 0;

    mac_operand_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .len          (len),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid),
        .op_a         (op_a),
        .op_b         (op_b),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .mac_acc      (mac_acc)
    );

    always #5 clk = ~clk;

    // MAC: accumulates on the falling edge.
    always @(negedge clk) begin
        if (mac_clr)     mac_acc <= 32'd0;
        else if (mac_en) mac_acc <= mac_acc + 32'(op_a) * 32'(op_b);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int dot(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += a_m[i] * b_m[i];
        return s;
    endfunction

    function automatic int done_off(input int n);
        return (n == 0) ? 1 : n + 3;
    endfunction

    // Model update from the inputs sampled at each rising edge.
    always @(posedge clk) begin
        bit idle_now;
        model_live = 1;
        cyc++;
        if (reset) begin
            active = 0;
            rv_e   = 0;
            res_e  = 0;
        end else begin
            idle_now = !active || (k > done_off(L));
            if (wr_en && (idle_now || (active && k == done_off(L)))) begin
                if (wr_sel) b_m[wr_addr] = int'(wr_data);
                else        a_m[wr_addr] = int'(wr_data);
            end
            if (start && idle_now) begin
                active  = 1;
                k       = 1;
                L       = (int'(len) > 16) ? 16 : int'(len);
                exp_dot = dot(L);
                rv_e    = 0;
            end else if (active) begin
                k++;
            end
            if (active && k == done_off(L)) begin
                rv_e  = 1;
                res_e = exp_dot;
            end
        end
    end

    // Per-cycle comparison of every output against the timeline model.
    always @(negedge clk) begin
        bit en_e, clr_e, busy_e, done_e;
        if (model_live) begin
            en_e   = active && L > 0 && k >= 2 && k <= L + 1;
            clr_e  = active && L > 0 && k == 1;
            busy_e = active && L > 0 && k >= 1 && k <= L + 2;
            done_e = active && k == done_off(L);
            chk("mac_en", mac_en, en_e);
            chk("mac_clr", mac_clr, clr_e);
            chk("busy", busy, busy_e);
            chk("done", done, done_e);
            chk("result_valid", result_valid, rv_e);
            if (rv_e) chk("result", result, res_e);
            if (en_e) begin
                chk("op_a", op_a, a_m[k-2]);
                chk("op_b", op_b, b_m[k-2]);
            end else if (busy_e) begin
                chk("op_a_idle", op_a, 0);
                chk("op_b_idle", op_b, 0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input bit sel, input int addr, input int data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = 8'(data);
        step();
        wr_en = 1'b0;
    endtask

    // mode: 0 quiet, 1 random write noise, 2 one write to A[0] during RUN.
    task automatic run(input int ln, input int mode, input int lat_exp);
        int n;
        len = 5'(ln); start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!done && n < 64) begin
            if (mode == 1) begin
                wr_en = 1'($urandom); wr_sel = 1'($urandom);
                wr_addr = 4'($urandom); wr_data = 8'($urandom);
            end else if (mode == 2 && n == 2) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd99;
            end else begin
                wr_en = 1'b0;
            end
            step();
            n++;
        end
        wr_en = 1'b0;
        chk("latency", n, lat_exp);
        step();
    endtask

    initial begin
        int cnt;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_result", result, 0);

        for (int i = 0; i < 16; i++) begin
            wr(0, i, $urandom_range(0, 255));
            wr(1, i, $urandom_range(0, 255));
        end

        // Basic dot product.
        for (int i = 0; i < 4; i++) begin
            wr(0, i, i + 1);
            wr(1, i, i + 5);
        end
        run(4, 0, 7);
        chk("basic_result", result, 70);

        // Full scale and length clamp.
        for (int i = 0; i < 16; i++) begin
            wr(0, i, 255);
            wr(1, i, 255);
        end
        run(16, 0, 19);
        chk("full_result", result, 1040400);
        run(20, 0, 19);
        chk("clamp_result", result, 1040400);

        // Zero length.
        run(0, 0, 1);
        chk("len0_result", result, 0);
        chk("len0_valid", result_valid, 1);

        // Write during RUN is dropped.
        for (int i = 0; i < 4; i++) begin
            wr(0, i, i + 1);
            wr(1, i, i + 5);
        end
        run(4, 2, 7);
        chk("busy_wr_result", result, 70);
        run(4, 0, 7);
        chk("rerun_result", result, 70);

        // Reset in the third RUN cycle.
        len = 5'd4; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_mac_en", mac_en, 0);
        chk("midrst_valid", result_valid, 0);
        step();
        run(4, 0, 7);
        chk("after_rst_result", result, 70);

        // Starts during RUN and in the DONE cycle are ignored.
        len = 5'd4; start = 1'b1;
        step();
        cnt = 0;
        for (int n = 1; n < 16; n++) begin
            if (done) cnt++;
            start = (n == 3 || n == 7);
            step();
        end
        start = 1'b0;
        chk("single_done", cnt, 1);

        // New data, then a run started one cycle after done.
        for (int i = 0; i < 4; i++) wr(0, i, i + 10);
        run(4, 0, 7);
        chk("new_data_result", result, 304);
        run(3, 0, 6);
        chk("b2b_result", result, 200);

        // Randomised runs with write noise.
        for (int it = 0; it < 25; it++) begin
            int ln, nw;
            nw = $urandom_range(0, 5);
            for (int j = 0; j < nw; j++) wr(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 255));
            ln = $urandom_range(0, 31);
            run(ln, 1, done_off((ln > 16) ? 16 : ln));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cycle %0d: got running expected finished", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Upstream feeder for the 8x8->32 multiply-accumulate unit.
- Holds two operand vectors A and B in local buffers loaded over a simple write port.
- On a start pulse it clears the MAC, then streams one operand pair per cycle with the MAC enable asserted.
- After the last pair it captures the 32-bit accumulator and reports the dot product with a done pulse.

Parameters:
- DEPTH, 16, maximum vector length in pairs (power of two, at least 2).
- AW, $clog2(DEPTH), buffer address width; localparam, not overridable.
- ACC_W, 32, accumulator/result width; must match the MAC.

Ports:
- clk  in  1  system clock; this block uses rising edges only.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  buffer write strobe.
- wr_sel  in  1  write target: 0 = buffer A, 1 = buffer B.
- wr_addr  in  AW  buffer write address.
- wr_data  in  8  unsigned operand byte.
- len  in  AW+1  number of pairs to process; sampled when start is accepted.
- start  in  1  one-cycle request to begin a dot product.
- busy  out  1  high from the cycle after start is accepted until the capture cycle.
- done  out  1  one-cycle pulse when result becomes valid.
- result  out  ACC_W  captured dot product.
- result_valid  out  1  high from done until the next accepted start or reset.
- op_a  out  8  operand to the MAC multiplier input A.
- op_b  out  8  operand to the MAC multiplier input B.
- mac_en  out  1  MAC accumulate enable.
- mac_clr  out  1  MAC clear, drives the MAC reset input.
- mac_acc  in  ACC_W  MAC accumulator output.

Behaviour:
- **Reset:** synchronous, active-high; all outputs are registered and reset to 0, and the FSM returns to IDLE. Buffer contents are not reset and are retained.
- **MAC clocking:** the MAC updates on the falling clk edge, so values driven at rising edge k are accumulated mid-cycle k. mac_acc is therefore stable at the next rising edge.
- **FSM states:** IDLE, CLEAR, RUN, DRAIN, DONE.
- **IDLE:**
  - start=1 with len!=0: latch len_eff = min(len, DEPTH), clear result_valid, go to CLEAR.
  - start=1 with len==0: go to DONE with result=0; no MAC activity.
- **CLEAR** (1 cycle): mac_clr=1, mac_en=0, busy=1; index reset to 0; next state RUN.
- **RUN** (len_eff cycles): op_a=A[idx], op_b=B[idx], mac_en=1, busy=1. idx increments each cycle; on idx==len_eff-1 the next state is DRAIN.
- **DRAIN** (1 cycle): mac_en=0, op_a=op_b=0, busy=1; result<=mac_acc at the end of the cycle; next state DONE.
- **DONE** (1 cycle): done=1, result_valid=1, busy=0; next state IDLE.
- **Timing:** with start sampled at cycle 0, the clear is in cycle 1, pairs are in cycles 2..len_eff+1, capture is at the end of cycle len_eff+2, and done is in cycle len_eff+3. Total latency from start to done is len_eff+3 cycles.
- **Arithmetic:** operands are unsigned. No overflow check is needed: the maximum sum is 16*255*255=1,040,400, which fits in 32 bits. result is a plain copy of mac_acc.
- **Writes:** wr_en is honoured only in IDLE and DONE; writes during CLEAR, RUN or DRAIN are dropped. A write and a start in the same IDLE cycle: the write commits, but the run uses the pre-write contents only if the address has already been streamed. Because the write completes before the first RUN read, the write is visible to the run.
- **start outside IDLE:** ignored, with no queueing. A start in the DONE cycle is also ignored; back-to-back runs need start one cycle after done at the earliest.
- **Reset mid-run:** mac_en and mac_clr drop to 0 in the same cycle reset is sampled, and result_valid is cleared. The MAC accumulator is left as-is; the next run's CLEAR reinitialises it.
- **Outputs outside RUN:** mac_en is never high outside RUN, and mac_clr is never high outside CLEAR.

Decomposition:
- **Shared package:** FSM state encoding (IDLE..DONE), the WR_SEL_A/WR_SEL_B constants, and the ACC_W default.
- **Sub-module `mac_operand_buffer`:** two DEPTH x 8 register arrays, one write port with a select input, and a common-address asynchronous dual read returning A[idx] and B[idx].
- **Top-level contents:** the sequencer keeps the FSM, the index counter, and the output registers.

Test Plan:
- **Basic dot product:** write A=1,2,3,4 and B=5,6,7,8; len=4; start -> mac_clr in cycle 1, mac_en in cycles 2-5, done in cycle 7, result=70.
- **Full-scale:** A=B=255 at all 16 entries, len=16 -> result=1,040,400, done exactly 19 cycles after start.
- **len=0:** start -> done on the next cycle, result=0, mac_en and mac_clr never asserted. **len=20:** clamps to 16 pairs.
- **Write while busy:** wr_en to A[0]=99 during RUN is dropped; a rerun gives the same result as before.
- **Reset mid-run:** assert reset during the 3rd RUN cycle -> next cycle busy=0, mac_en=0, result_valid=0. A fresh run with the same data gives the correct 70.
- **start during busy:** ignored, with exactly one done pulse. A second run started one cycle after done with different data gives the new correct result.
